// File: rtl/bram_read_arbiter_if.sv
// Engine-side request/response bus of the BRAM read arbiter.
// master = engine side, slave = arbiter side.
interface bram_read_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/bram_read_arbiter.sv
// Shares one BRAM read port between N_REQ engines (round-robin) and a host that has absolute priority.
// Optional engine stall counter is built when BRAM_ARB_STALL_CNT_EN is defined.
module bram_read_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_host_sel,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic                  i_host_valid,
  output logic [DATA_WIDTH-1:0] o_host_data,
  bram_read_arbiter_if.slave    eng,
  output logic [ADDR_WIDTH-1:0] o_bram_r_addr,
  output logic                  o_bram_r_valid,
  input  logic [DATA_WIDTH-1:0] i_bram_r_data,
  output logic [REG_WIDTH-1:0]  o_stall_cnt
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]      r_rr_ptr;
  logic [N_REQ-1:0]      r_tag;
  logic [PTR_W-1:0]      w_grant_idx;
  logic                  w_grant_any;
  logic                  w_grant_vld;
  logic [N_REQ-1:0]      w_req_ready;
  logic [ADDR_WIDTH-1:0] w_eng_addr;

  // First pending request found scanning upward (with wrap) from the round-robin pointer.
  always_comb begin : grant_search
    int   j;
    logic hit;
    j           = 0;
    hit         = 1'b0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j           = int'(r_rr_ptr) + k;
      j           = (j >= N_REQ) ? (j - N_REQ) : j;
      hit         = !w_grant_any && eng.req_valid[j];
      w_grant_idx = hit ? PTR_W'(j) : w_grant_idx;
      w_grant_any = w_grant_any | hit;
    end
  end

  assign w_grant_vld = w_grant_any && !i_host_sel && !i_rst;
  assign w_req_ready = w_grant_vld ? (N_REQ'(1) << w_grant_idx) : '0;
  assign w_eng_addr  = eng.req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];

  // BRAM read port mux: host owns it while selected, otherwise the granted engine.
  always_comb begin
    o_bram_r_addr  = '0;
    o_bram_r_valid = 1'b0;
    if (i_rst) begin
      o_bram_r_addr  = '0;
      o_bram_r_valid = 1'b0;
    end else if (i_host_sel) begin
      o_bram_r_addr  = i_host_addr;
      o_bram_r_valid = i_host_valid;
    end else if (w_grant_vld) begin
      o_bram_r_addr  = w_eng_addr;
      o_bram_r_valid = 1'b1;
    end else begin
      o_bram_r_addr  = '0;
      o_bram_r_valid = 1'b0;
    end
  end

  // Round-robin pointer and one-cycle response tag for the BRAM's read latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
      r_tag    <= '0;
    end else begin
      r_tag <= w_req_ready;
      if (w_grant_vld) begin
        r_rr_ptr <= (w_grant_idx == PTR_W'(N_REQ - 1)) ? '0 : (w_grant_idx + PTR_W'(1));
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // Response is gated by reset so a read in flight when reset hits is dropped.
  assign eng.req_ready = w_req_ready;
  assign eng.rsp_valid = r_tag & {N_REQ{~i_rst}};
  assign eng.rsp_data  = i_bram_r_data;
  assign o_host_data   = i_bram_r_data;

`ifdef BRAM_ARB_STALL_CNT_EN
  logic [REG_WIDTH-1:0] r_stall_cnt;
  logic                 w_stall;

  assign w_stall = |(eng.req_valid & ~w_req_ready);

  // Saturating count of cycles in which some engine waited, host-blocked cycles included.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {REG_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + REG_WIDTH'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif
endmodule
